// File: rtl/fp8_e4m3_pkg.sv
// Shared E4M3 constants, controller state encoding and the rounding helpers used by the fma.
// Every E4M3 code is finite here: 0x7F (480.0) is the largest magnitude and overflow saturates to it.
package fp8_e4m3_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] ONE     = 8'h38;
    localparam logic [7:0] MAX_POS = 8'h7F;
    localparam logic [7:0] ZERO    = 8'h00;

    // Magnitude code -> fixed point with 9 fractional bits (2^-9 is the smallest subnormal).
    function automatic logic [17:0] mag9(input logic [6:0] c);
        logic [3:0] m;
        int         e;
        m = {(c[6:3] != 4'd0), c[2:0]};
        e = (c[6:3] == 4'd0) ? 1 : int'(c[6:3]);
        return 18'(m) << (e - 1);
    endfunction

    // Fixed point with 18 fractional bits -> magnitude code, round to nearest even, saturating.
    // The code is (d-9)*8 + q, so a mantissa carry rolls into the exponent for free.
    function automatic logic [6:0] round_mag(input logic [35:0] m);
        int          p;
        int          d;
        int          code;
        logic [35:0] q;
        logic [35:0] rem;
        logic [35:0] half;
        logic        up;
        p = 0;
        for (int i = 0; i < 36; i++) begin
            if (m[i]) p = i;
        end
        d    = (p - 3 > 9) ? p - 3 : 9;
        q    = m >> d;
        rem  = m & ((36'd1 << d) - 36'd1);
        half = 36'd1 << (d - 1);
        up   = (rem > half) || ((rem == half) && q[0]);
        q    = q + {35'd0, up};
        code = (d - 9) * 8 + int'(q[4:0]);
        return (code > 127) ? MAX_POS[6:0] : code[6:0];
    endfunction

endpackage

// File: rtl/fp8_e4m3_fma.sv
// Combinational E4M3 fused step y = round(round(a*b) + c); exact cancellation gives +0,
// while a zero from two negative-zero operands (or a rounded-away product) keeps its sign.
module fp8_e4m3_fma
    import fp8_e4m3_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    output logic [7:0] y
);

    logic [3:0]  ma, mb, ea, eb;
    logic [7:0]  mprod;
    logic [4:0]  sh;
    logic [35:0] prod;
    logic [7:0]  p;
    logic [17:0] mag_p, mag_c;
    logic [18:0] sum;
    logic        s;

    always_comb begin
        ma    = {(a[6:3] != 4'd0), a[2:0]};
        mb    = {(b[6:3] != 4'd0), b[2:0]};
        ea    = (a[6:3] == 4'd0) ? 4'd1 : a[6:3];
        eb    = (b[6:3] == 4'd0) ? 4'd1 : b[6:3];
        mprod = {4'd0, ma} * {4'd0, mb};
        sh    = {1'b0, ea} + {1'b0, eb} - 5'd2;
        prod  = {28'd0, mprod} << sh;
        p     = {a[7] ^ b[7], round_mag(prod)};
        mag_p = mag9(p[6:0]);
        mag_c = mag9(c[6:0]);
        if (p[7] == c[7]) begin
            sum = {1'b0, mag_p} + {1'b0, mag_c};
            s   = p[7];
        end else if (mag_p >= mag_c) begin
            sum = {1'b0, mag_p} - {1'b0, mag_c};
            s   = p[7];
        end else begin
            sum = {1'b0, mag_c} - {1'b0, mag_p};
            s   = c[7];
        end
        if (sum == 19'd0) s = p[7] & c[7];
        y = {s, round_mag({8'd0, sum, 9'd0})};
    end

endmodule

// File: rtl/fp8_e4m3_dot_accum.sv
// Streaming E4M3 dot-product accumulator with valid/ready handshakes on both sides.
//   state | meaning
//   ACCUM | accepting beats, folding a*b into acc
//   HOLD  | result presented on out_*, waiting for out_ready
module fp8_e4m3_dot_accum
    import fp8_e4m3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [7:0]       fma_y;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_next;
    logic             accept;

    fp8_e4m3_fma u_fma (
        .a (in_a),
        .b (in_b),
        .c (acc),
        .y (fma_y)
    );

    assign in_ready = (state == ACCUM) && !clr && !rst;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign sat_next = sat || (fma_y[6:0] == MAX_POS[6:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= ZERO;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= ZERO;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clr) begin
                        acc <= ZERO;
                        cnt <= '0;
                        sat <= 1'b0;
                    end else if (accept) begin
                        acc <= fma_y;
                        cnt <= cnt_inc;
                        sat <= sat_next;
                        if (in_last) begin
                            out_data  <= fma_y;
                            out_count <= cnt_inc;
                            out_sat   <= sat_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // clr is deliberately ignored here so a pending result is never lost
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= ZERO;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_e4m3_dot_accum.sv
// Randomised and directed bench for fp8_e4m3_dot_accum against a real-number E4M3 reference.
module tb_fp8_e4m3_dot_accum;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, clr, in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic [7:0]    in_a, in_b, out_data;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] m_acc, m_od;
    int         m_cnt, m_oc;
    bit         m_sat, m_os, m_ov, m_hold;

    fp8_e4m3_dot_accum #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic real dec(input logic [7:0] c);
        real v;
        int  e;
        e = int'(c[6:3]);
        if (e == 0) v = (real'(c[2:0]) / 8.0) * (2.0 ** (-6));
        else        v = (1.0 + real'(c[2:0]) / 8.0) * (2.0 ** (e - 7));
        return c[7] ? -v : v;
    endfunction

    // Nearest representable magnitude, ties to the even code; anything past 480 lands on 0x7F.
    function automatic logic [7:0] enc(input real x, input logic zs);
        real  mag, d, best_d;
        int   best;
        logic s;
        mag    = (x < 0.0) ? -x : x;
        best   = 0;
        best_d = mag;
        for (int k = 1; k < 128; k++) begin
            d = dec(8'(k)) - mag;
            if (d < 0.0) d = -d;
            if (d < best_d || (d == best_d && (k % 2) == 0)) begin
                best   = k;
                best_d = d;
            end
        end
        s = (x < 0.0) ? 1'b1 : (x > 0.0) ? 1'b0 : zs;
        return {s, 7'(best)};
    endfunction

    function automatic logic [7:0] fma_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] pc;
        pc = enc(dec(a) * dec(b), a[7] ^ b[7]);
        return enc(dec(pc) + dec(c), pc[7] & c[7]);
    endfunction

    task automatic model_reset();
        m_acc = 8'h00; m_od = 8'h00; m_cnt = 0; m_oc = 0;
        m_sat = 0; m_os = 0; m_ov = 0; m_hold = 0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic l, input logic c, input logic r);
        logic [7:0] res;
        in_valid = v; in_a = a; in_b = b; in_last = l; clr = c; out_ready = r;
        #1;
        chk("in_ready", in_ready, !m_hold && !c);
        if (!m_hold) begin
            if (c) begin
                m_acc = 8'h00; m_cnt = 0; m_sat = 0;
            end else if (v) begin
                res   = fma_ref(a, b, m_acc);
                m_acc = res;
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_sat = m_sat || (res[6:0] == 7'h7F);
                if (l) begin
                    m_od = res; m_oc = m_cnt; m_os = m_sat; m_ov = 1; m_hold = 1;
                end
            end
        end else if (r) begin
            m_ov = 0; m_acc = 8'h00; m_cnt = 0; m_sat = 0; m_hold = 0;
        end
        @(negedge clk);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_count", out_count, m_oc);
            chk("out_sat", out_sat, m_os);
        end
    endtask

    task automatic async_rst();
        in_valid = 0; clr = 0; out_ready = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_count", out_count, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_code();
        if ($urandom_range(1, 0) == 1) return {1'($urandom), 7'($urandom_range(68, 32))};
        return 8'($urandom);
    endfunction

    initial begin
        rst = 1'b0; clr = 0; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_sat", out_sat, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single 1.0*1.0
        cycle(1, 8'h38, 8'h38, 1, 0, 0);
        chk("single_data", out_data, 8'h38);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // four ones -> 4.0
        for (int i = 0; i < 4; i++) cycle(1, 8'h38, 8'h38, (i == 3), 0, 0);
        chk("four_data", out_data, 8'h48);
        chk("four_count", out_count, 4);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // negative result, then saturation
        cycle(1, 8'h38, 8'hB8, 1, 0, 0);
        chk("neg_data", out_data, 8'hB8);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);
        cycle(1, 8'h7F, 8'h7F, 1, 0, 0);
        chk("sat_data", out_data, 8'h7F);
        chk("sat_flag", out_sat, 1);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // back-pressure on the result while beats are offered
        cycle(1, 8'h38, 8'h38, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'h40, 8'h40, 0, 0, 0);
        cycle(1, 8'h40, 8'h40, 0, 0, 1);
        cycle(1, 8'h38, 8'h40, 1, 0, 0);
        chk("after_hold_data", out_data, 8'h40);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // clr discards partial sum; clr in HOLD is ignored
        cycle(1, 8'h38, 8'h38, 0, 0, 0);
        cycle(1, 8'h38, 8'h38, 0, 0, 0);
        cycle(1, 8'h38, 8'h38, 0, 1, 0);
        cycle(1, 8'h38, 8'h38, 1, 0, 0);
        chk("clr_data", out_data, 8'h38);
        chk("clr_count", out_count, 1);
        cycle(0, 8'h00, 8'h00, 0, 1, 0);
        chk("hold_clr_data", out_data, 8'h38);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // counter saturation
        for (int i = 0; i < 20; i++) cycle(1, 8'h30, 8'h30, (i == 19), 0, 0);
        chk("cnt_saturate", out_count, CNT_MAX);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // asynchronous reset mid-vector and in HOLD
        cycle(1, 8'h38, 8'h38, 0, 0, 0);
        cycle(1, 8'h38, 8'h38, 0, 0, 0);
        async_rst();
        cycle(1, 8'h38, 8'h38, 1, 0, 0);
        async_rst();
        cycle(1, 8'h38, 8'h38, 1, 0, 0);
        chk("post_rst_data", out_data, 8'h38);
        cycle(0, 8'h00, 8'h00, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(9, 0) < 7), rnd_code(), rnd_code(),
                  ($urandom_range(3, 0) == 0), ($urandom_range(19, 0) == 0),
                  ($urandom_range(9, 0) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
